// File: rtl/io_port_responder.sv
// Peripheral responder for the CPU programmed-I/O bus: synchronises the strobes,
// decodes four registers and bridges them to an input FIFO and an output FIFO.
module io_port_responder #(
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       nPREQ,
    input  logic       nPRD,
    input  logic       nPWR,
    input  logic [1:0] IOAD,
    inout  wire  [7:0] IODB,
    input  logic [7:0] in_data,
    input  logic       in_stb,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Pipelines: index SYNC-1 is the last synchroniser stage (s2), index SYNC is s3.
    logic [SYNC:0] preq_p, prd_p, pwr_p;
    logic [1:0]    ad_p [0:SYNC];
    logic [7:0]    db_p [0:SYNC];
    logic [SYNC-1:0] flush;
    logic          armed;

    logic preq_s2, preq_s3, prd_s2, prd_s3, pwr_s2, pwr_s3;
    logic [1:0] ad_s2, ad_s3;
    logic [7:0] db_s3;

    assign preq_s2 = preq_p[SYNC-1];
    assign preq_s3 = preq_p[SYNC];
    assign prd_s2  = prd_p[SYNC-1];
    assign prd_s3  = prd_p[SYNC];
    assign pwr_s2  = pwr_p[SYNC-1];
    assign pwr_s3  = pwr_p[SYNC];
    assign ad_s2   = ad_p[SYNC-1];
    assign ad_s3   = ad_p[SYNC];
    assign db_s3   = db_p[SYNC];

    always_ff @(posedge clk) begin
        if (!nRST) begin
            preq_p <= '1;
            prd_p  <= '1;
            pwr_p  <= '1;
            for (int i = 0; i <= SYNC; i++) begin
                ad_p[i] <= '0;
                db_p[i] <= '0;
            end
            flush <= '0;
            armed <= 1'b0;
        end else begin
            preq_p <= {preq_p[SYNC-1:0], nPREQ};
            prd_p  <= {prd_p[SYNC-1:0], nPRD};
            pwr_p  <= {pwr_p[SYNC-1:0], nPWR};
            ad_p[0] <= IOAD;
            db_p[0] <= IODB;
            for (int i = 1; i <= SYNC; i++) begin
                ad_p[i] <= ad_p[i-1];
                db_p[i] <= db_p[i-1];
            end
            flush <= {flush[SYNC-2:0], 1'b1};
            // Only a genuinely idle bus (not reset-filled stages) arms decoding, so a
            // strobe that straddles reset can never start, end or commit anything.
            if (flush[SYNC-1] && prd_s2 && pwr_s2)
                armed <= 1'b1;
        end
    end

    logic rd_start, rd_end, wr_cmt;
    assign rd_start = armed & prd_s3 & ~prd_s2 & ~preq_s2 & pwr_s2;
    assign rd_end   = armed & ~prd_s3 & prd_s2 & ~preq_s3 & pwr_s3;
    assign wr_cmt   = armed & ~pwr_s3 & pwr_s2 & ~preq_s3 & prd_s3;

    // Input FIFO
    logic [7:0]    in_mem [0:DEPTH-1];
    logic [AW-1:0] in_wp, in_rp;
    logic [CW-1:0] in_cnt;
    logic          in_full, in_push, in_pop, in_ovf, rd_pop;

    assign in_full = (in_cnt == FULL_CNT);
    assign in_pop  = rd_end & rd_pop;
    assign in_push = in_stb & (~in_full | in_pop);

    // Output FIFO
    logic [7:0]    out_mem [0:DEPTH-1];
    logic [AW-1:0] out_wp, out_rp;
    logic [CW-1:0] out_cnt;
    logic          out_full, out_push, out_pop, out_werr, wr_out, wr_stat;

    assign out_full  = (out_cnt == FULL_CNT);
    assign out_valid = (out_cnt != '0);
    assign out_pop   = out_ready & out_valid;
    assign wr_out    = wr_cmt & (ad_s3 == 2'd1);
    assign wr_stat   = wr_cmt & (ad_s3 == 2'd2);
    assign out_push  = wr_out & (~out_full | out_pop);
    assign out_data  = out_valid ? out_mem[out_rp] : 8'h00;

    logic [7:0] stat;
    assign stat = {1'b0, 3'(in_cnt), out_werr, in_ovf, out_full, (in_cnt != '0)};

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wp] <= in_data;
        if (out_push)
            out_mem[out_wp] <= db_s3;
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            in_wp    <= '0;
            in_rp    <= '0;
            in_cnt   <= '0;
            out_wp   <= '0;
            out_rp   <= '0;
            out_cnt  <= '0;
            in_ovf   <= 1'b0;
            out_werr <= 1'b0;
        end else begin
            if (in_push)
                in_wp <= in_wp + AW'(1);
            if (in_pop)
                in_rp <= in_rp + AW'(1);
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + CW'(1);
                2'b01:   in_cnt <= in_cnt - CW'(1);
                default: in_cnt <= in_cnt;
            endcase
            if (out_push)
                out_wp <= out_wp + AW'(1);
            if (out_pop)
                out_rp <= out_rp + AW'(1);
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
            in_ovf   <= (in_ovf & ~(wr_stat & db_s3[2])) | (in_stb & in_full & ~in_pop);
            out_werr <= (out_werr & ~(wr_stat & db_s3[3])) | (wr_out & out_full & ~out_pop);
        end
    end

    // Register file and read capture
    logic [7:0] rd_data, last_out, scr;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            rd_data  <= 8'h00;
            rd_pop   <= 1'b0;
            last_out <= 8'h00;
            scr      <= 8'h00;
        end else begin
            if (rd_start) begin
                // Whether to pop is decided here, so an empty FIFO never underflows.
                rd_pop <= (ad_s2 == 2'd0) && (in_cnt != '0);
                case (ad_s2)
                    2'd0:    rd_data <= (in_cnt != '0) ? in_mem[in_rp] : 8'h00;
                    2'd1:    rd_data <= last_out;
                    2'd2:    rd_data <= stat;
                    default: rd_data <= scr;
                endcase
            end else if (rd_end || (!prd_s2 && !pwr_s2)) begin
                rd_pop <= 1'b0;
            end
            if (wr_out)
                last_out <= db_s3;
            if (wr_cmt && ad_s3 == 2'd3)
                scr <= db_s3;
        end
    end

    logic oe;
    assign oe   = nRST & ~nPREQ & ~nPRD;
    assign IODB = oe ? rd_data : 8'hzz;

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed bus scenarios plus random traffic against
// a transaction-level model built from queues.
module tb_io_port_responder;

    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nRST, nPREQ, nPRD, nPWR;
    logic [1:0] IOAD;
    wire  [7:0] IODB;
    logic       cpu_oe;
    logic [7:0] cpu_dout;
    logic [7:0] in_data;
    logic       in_stb;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    always #5 clk = ~clk;

    // Released bus floats high, so high-Z reads back as 0xFF.
    assign IODB = cpu_oe ? cpu_dout : 8'hzz;
    generate
        for (genvar g = 0; g < 8; g++) begin : g_pu
            pullup (IODB[g]);
        end
    endgenerate

    io_port_responder #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .nPREQ     (nPREQ),
        .nPRD      (nPRD),
        .nPWR      (nPWR),
        .IOAD      (IOAD),
        .IODB      (IODB),
        .in_data   (in_data),
        .in_stb    (in_stb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [7:0] exp_in_q[$];
    logic [7:0] exp_out_q[$];
    logic [7:0] m_last, m_scr;
    logic       m_ovf, m_werr;

    task automatic m_reset();
        exp_in_q.delete();
        exp_out_q.delete();
        m_last = 8'h00;
        m_scr  = 8'h00;
        m_ovf  = 1'b0;
        m_werr = 1'b0;
    endtask

    function automatic logic [7:0] m_stat();
        logic [2:0] c;
        c = 3'(exp_in_q.size());
        return {1'b0, c, m_werr, m_ovf, exp_out_q.size() == DEPTH, exp_in_q.size() != 0};
    endfunction

    task automatic m_read(input logic [1:0] a, output logic [7:0] d);
        case (a)
            2'd0: d = (exp_in_q.size() != 0) ? exp_in_q.pop_front() : 8'h00;
            2'd1: d = m_last;
            2'd2: d = m_stat();
            default: d = m_scr;
        endcase
    endtask

    task automatic m_write(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd1: begin
                m_last = d;
                if (exp_out_q.size() < DEPTH) exp_out_q.push_back(d);
                else m_werr = 1'b1;
            end
            2'd2: begin
                if (d[2]) m_ovf = 1'b0;
                if (d[3]) m_werr = 1'b0;
            end
            2'd3: m_scr = d;
            default: ;
        endcase
    endtask

    // Clock / drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d,
                            input bit stb_end, input logic [7:0] stb_byte);
        IOAD  = a;
        nPREQ = 1'b0;
        tick();
        nPRD = 1'b0;
        wait_cycles(SYNC + 3);
        d    = IODB;
        nPRD = 1'b1;
        tick();
        tick();
        if (stb_end) begin
            in_data = stb_byte;
            in_stb  = 1'b1;
        end
        tick();
        in_stb = 1'b0;
        wait_cycles(SYNC);
        nPREQ = 1'b1;
        wait_cycles(4);
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d,
                             input bit use_preq, input bit sink_pop);
        IOAD     = a;
        cpu_dout = d;
        cpu_oe   = 1'b1;
        nPREQ    = ~use_preq;
        tick();
        nPWR = 1'b0;
        wait_cycles(SYNC + 2);
        nPWR = 1'b1;
        tick();
        tick();
        if (sink_pop) out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_cycles(SYNC);
        nPREQ  = 1'b1;
        cpu_oe = 1'b0;
        wait_cycles(4);
    endtask

    task automatic do_read(input logic [1:0] a, input string tag);
        logic [7:0] exp, got;
        m_read(a, exp);
        cpu_read(a, got, 1'b0, 8'h00);
        check(tag, got, exp);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        m_write(a, d);
        cpu_write(a, d, 1'b1, 1'b0);
    endtask

    task automatic push_in(input logic [7:0] d);
        in_data = d;
        in_stb  = 1'b1;
        tick();
        in_stb = 1'b0;
        tick();
        if (exp_in_q.size() < DEPTH) exp_in_q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic check_out(input string tag);
        check({tag, "_valid"}, out_valid, exp_out_q.size() != 0);
        check({tag, "_data"}, out_data, (exp_out_q.size() != 0) ? exp_out_q[0] : 8'h00);
    endtask

    task automatic drain_one(input string tag);
        check_out(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        if (exp_out_q.size() != 0) void'(exp_out_q.pop_front());
    endtask

    initial begin
        logic [7:0] got, exp, b;
        logic [1:0] a;
        nRST = 1'b0; nPREQ = 1'b1; nPRD = 1'b1; nPWR = 1'b1; IOAD = 2'd0;
        cpu_oe = 1'b0; cpu_dout = 8'h00; in_data = 8'h00; in_stb = 1'b0; out_ready = 1'b0;
        m_reset();

        // Reset state
        wait_cycles(2);
        check("rst_iodb_z", IODB, 8'hff);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        nRST = 1'b1;
        wait_cycles(4);
        do_read(2'd2, "rst_stat");

        // Input FIFO through addr 0
        push_in(8'hA7);
        push_in(8'h11);
        do_read(2'd2, "in2_stat");
        do_read(2'd0, "in_rd_a7");
        do_read(2'd2, "in1_stat");
        do_read(2'd0, "in_rd_11");
        do_read(2'd0, "in_rd_empty");
        do_read(2'd2, "in0_stat");

        // Output FIFO overfill and drain
        for (int i = 0; i < 5; i++) do_write(2'd1, 8'hAE);
        check_out("ofull");
        do_read(2'd2, "ofull_stat");
        do_read(2'd1, "last_out");
        for (int i = 0; i < 4; i++) drain_one("odrain");
        check_out("oempty");
        do_write(2'd2, 8'h08);
        do_read(2'd2, "werr_clr_stat");

        // Input overflow and sticky clear
        for (int i = 0; i < 5; i++) push_in(8'(8'h30 + i));
        do_read(2'd2, "iovf_stat");
        do_write(2'd2, 8'h04);
        do_read(2'd2, "iovf_clr_stat");

        // Full input FIFO: pop and push land on the same edge
        m_read(2'd0, exp);
        cpu_read(2'd0, got, 1'b1, 8'h3C);
        check("in_full_pp_data", got, exp);
        exp_in_q.push_back(8'h3C);
        do_read(2'd2, "in_full_pp_stat");
        for (int i = 0; i < 4; i++) do_read(2'd0, "in_full_pp_order");

        // Scratch register, and an access without nPREQ
        do_write(2'd3, 8'h5C);
        do_read(2'd3, "scr");
        cpu_write(2'd3, 8'h77, 1'b0, 1'b0);
        do_read(2'd3, "scr_nopreq");

        // Full output FIFO: CPU push and sink pop on the same edge
        for (int i = 0; i < 4; i++) do_write(2'd1, 8'(8'hC0 + i));
        check_out("o_pp_pre");
        void'(exp_out_q.pop_front());
        exp_out_q.push_back(8'hD5);
        m_last = 8'hD5;
        cpu_write(2'd1, 8'hD5, 1'b1, 1'b1);
        do_read(2'd2, "o_pp_stat");
        for (int i = 0; i < 4; i++) drain_one("o_pp_drain");
        check_out("o_pp_empty");

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            a = 2'($urandom_range(0, 3));
            b = 8'($urandom_range(0, 254));
            case ($urandom_range(0, 4))
                0: push_in(b);
                1: do_read(a, "rnd_read");
                2: do_write(a, b);
                3: drain_one("rnd_drain");
                default: do_read(2'd2, "rnd_stat");
            endcase
            check_out("rnd_out");
        end

        // Reset in the middle of an addr-0 read with two entries queued
        while (exp_in_q.size() != 0) do_read(2'd0, "flush_in");
        push_in(8'h61);
        push_in(8'h62);
        IOAD  = 2'd0;
        nPREQ = 1'b0;
        tick();
        nPRD = 1'b0;
        wait_cycles(SYNC + 3);
        check("midrd_drive", IODB, 8'h61);
        nRST = 1'b0;
        wait_cycles(2);
        m_reset();
        check("midrd_rst_z", IODB, 8'hff);
        nRST = 1'b1;
        wait_cycles(SYNC + 4);
        check("midrd_post_rst", IODB, 8'h00);
        nPRD = 1'b1;
        wait_cycles(SYNC + 3);
        check("midrd_release_z", IODB, 8'hff);
        nPREQ = 1'b1;
        wait_cycles(4);
        do_read(2'd2, "midrd_stat");
        do_read(2'd0, "midrd_empty");
        check_out("midrd_out");
        push_in(8'h9B);
        do_read(2'd0, "midrd_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
